multicycle_controller: RTL

- Multi-cycle successor to the single-cycle MIPS control unit.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and waits on ready handshakes from instruction and data memory.
- Adds a memory-wait watchdog, a retired-instruction counter, and sticky halt/error status.
- Drives the same datapath select encodings as the single-cycle controller (`defines.v`: ALU_SEL_*, GPR_WRITE_*, ALU_SRC_*, EXT_SEL_*, IFU_SEL_*, INST_*).

---
 rtl/multicycle_controller_if.sv | 26 ++
 rtl/multicycle_controller.sv | 122 ++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: control/handshake bundle between the multicycle controller and its datapath
interface multicycle_controller_if #(
    parameter int DEC_W = 6,
    parameter int CNT_W = 32
);
    logic [DEC_W-1:0] dec_inst;
    logic             zero, imem_ready, dmem_ready;
    logic             pc_write_en, ir_write_en, reg_write_en, reg_of_en;
    logic             mem_write_en, mem_read_en, imem_req;
    logic [1:0]       alu_sel, gpr_write_addr_sel, gpr_write_data_sel, ext_ctl, npc_sel;
    logic             alu_src_ctl, halt_sig, bus_err, bad_inst;
    logic [CNT_W-1:0] inst_count;
    logic [2:0]       state;
    modport master (
        input  dec_inst, zero, imem_ready, dmem_ready,
        output pc_write_en, ir_write_en, reg_write_en, reg_of_en, mem_write_en, mem_read_en,
               imem_req, alu_sel, gpr_write_addr_sel, gpr_write_data_sel, ext_ctl, npc_sel,
               alu_src_ctl, halt_sig, bus_err, bad_inst, inst_count, state
    );
    modport slave (
        output dec_inst, zero, imem_ready, dmem_ready,
        input  pc_write_en, ir_write_en, reg_write_en, reg_of_en, mem_write_en, mem_read_en,
               imem_req, alu_sel, gpr_write_addr_sel, gpr_write_data_sel, ext_ctl, npc_sel,
               alu_src_ctl, halt_sig, bus_err, bad_inst, inst_count, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB sequencer with memory watchdog, retire counter and sticky halt/error
module multicycle_controller #(
    parameter int DEC_W   = 6,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input logic clk,
    input logic reset,
    multicycle_controller_if.master bus
);
    localparam logic [DEC_W-1:0] I_ADDU = DEC_W'(1), I_SUBU = DEC_W'(2), I_SLT = DEC_W'(3),
        I_ORI = DEC_W'(4), I_LUI = DEC_W'(5), I_ADDI = DEC_W'(6), I_LW = DEC_W'(7),
        I_SW = DEC_W'(8), I_BEQ = DEC_W'(9), I_J = DEC_W'(10), I_JAL = DEC_W'(11),
        I_JR = DEC_W'(12), I_HLT = DEC_W'(13);
    localparam logic [1:0] A_ADD = 2'd0, A_SUB = 2'd1, A_OR = 2'd2, A_SLT = 2'd3;
    localparam logic [1:0] W_RT = 2'd0, W_RD = 2'd1, W_RA = 2'd2;
    localparam logic [1:0] D_ALU = 2'd0, D_MEM = 2'd1, D_PC = 2'd2;
    localparam logic S_EXT = 1'b0, S_GPR = 1'b1;
    localparam logic [1:0] E_SIGN = 2'd0, E_ZERO = 2'd1, E_LUI = 2'd2;
    localparam logic [1:0] N_NORM = 2'd0, N_REL = 2'd1, N_IRR = 2'd2, N_REG = 2'd3;
    localparam int WW = $clog2(TIMEOUT + 2);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    state_t           st, st_n;
    logic [DEC_W-1:0] op_q, op;
    logic [WW-1:0]    wcnt;
    logic [CNT_W-1:0] cnt;
    logic             halt_q, berr_q, known, rtype, jump, waiting, timeout_hit, retire;

    // DECODE sees the live decoder output; later states use the latched copy
    assign op          = (st == DECODE) ? bus.dec_inst : op_q;
    assign known       = op inside {[I_ADDU:I_HLT]};
    assign rtype       = op == I_ADDU || op == I_SUBU || op == I_SLT;
    assign jump        = op == I_J || op == I_JR || op == I_JAL;
    assign waiting     = (st == FETCH && !bus.imem_ready) || (st == MEM && !bus.dmem_ready);
    assign timeout_hit = TIMEOUT != 0 && waiting && (32'(wcnt) + 32'd1 == 32'(TIMEOUT));
    assign retire      = (st_n == FETCH && st != FETCH && !(st == DECODE && !known)) ||
                         (st == DECODE && op == I_HLT);
    assign bus.state      = st;
    assign bus.inst_count = cnt;
    assign bus.halt_sig   = halt_q;
    assign bus.bus_err    = berr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            st     <= FETCH;
            op_q   <= '0;
            wcnt   <= '0;
            cnt    <= '0;
            halt_q <= 1'b0;
            berr_q <= 1'b0;
        end else begin
            st   <= st_n;
            wcnt <= (waiting && st_n == st) ? wcnt + 1'b1 : '0;
            cnt  <= cnt + CNT_W'(retire);
            if (st == DECODE) op_q <= bus.dec_inst;
            if (st_n == HALT) halt_q <= 1'b1;
            if (timeout_hit) berr_q <= 1'b1;
        end
    end

    always_comb begin
        st_n                   = st;
        bus.pc_write_en        = 1'b0;
        bus.ir_write_en        = 1'b0;
        bus.reg_write_en       = 1'b0;
        bus.reg_of_en          = 1'b0;
        bus.mem_write_en       = 1'b0;
        bus.mem_read_en        = 1'b0;
        bus.imem_req           = 1'b0;
        bus.bad_inst           = 1'b0;
        bus.alu_sel            = A_ADD;
        bus.gpr_write_addr_sel = W_RT;
        bus.gpr_write_data_sel = D_ALU;
        bus.alu_src_ctl        = S_EXT;
        bus.ext_ctl            = E_SIGN;
        bus.npc_sel            = N_NORM;
        if (!reset && st inside {DECODE, EXEC, MEM, WB}) begin
            bus.alu_sel            = (op == I_SUBU || op == I_BEQ) ? A_SUB :
                                     op == I_SLT ? A_SLT : op == I_ORI ? A_OR : A_ADD;
            bus.gpr_write_addr_sel = rtype ? W_RD : op == I_JAL ? W_RA : W_RT;
            bus.gpr_write_data_sel = op == I_LW ? D_MEM : op == I_JAL ? D_PC : D_ALU;
            bus.alu_src_ctl        = (rtype || op == I_BEQ) ? S_GPR : S_EXT;
            bus.ext_ctl            = op == I_ORI ? E_ZERO : op == I_LUI ? E_LUI : E_SIGN;
        end
        if (!reset) begin
            case (st)
                FETCH: begin
                    bus.imem_req    = 1'b1;
                    bus.ir_write_en = bus.imem_ready;
                    bus.pc_write_en = bus.imem_ready;
                    st_n            = bus.imem_ready ? DECODE : FETCH;
                end
                DECODE: begin
                    bus.bad_inst     = !known;
                    bus.pc_write_en  = jump;
                    bus.reg_write_en = op == I_JAL;
                    bus.npc_sel      = op == I_JR ? N_REG : jump ? N_IRR : N_NORM;
                    st_n             = (!known || jump) ? FETCH : op == I_HLT ? HALT : EXEC;
                end
                EXEC: begin
                    bus.pc_write_en = op == I_BEQ && bus.zero;
                    bus.npc_sel     = (op == I_BEQ && bus.zero) ? N_REL : N_NORM;
                    st_n            = op == I_BEQ ? FETCH : (op == I_LW || op == I_SW) ? MEM : WB;
                end
                MEM: begin
                    bus.mem_write_en = op == I_SW;
                    bus.mem_read_en  = op == I_LW;
                    st_n             = !bus.dmem_ready ? MEM : op == I_LW ? WB : FETCH;
                end
                WB: begin
                    bus.reg_write_en = 1'b1;
                    bus.reg_of_en    = op == I_ADDI;
                    st_n             = FETCH;
                end
                default: st_n = HALT;
            endcase
            if (timeout_hit) st_n = HALT;
        end
    end
endmodule
